alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single core ALU between two requesters: port 0 (EX stage) and port 1 (address-gen/CSR unit).
//  Arbitrates each cycle, drives the instantiated alu with the granted operands, and registers the result in a 1-deep output stage.
//  The result returns on one response channel tagged with the requester id. Sits between decode/EX issue logic and the ALU.
// PARAMETERS
//  XLEN_P      `XLEN (32)  operand/result width; must equal `XLEN of the instantiated alu
// PORTS
//  clk         in   1      core clock
//  rstn        in   1      asynchronous active-low reset
//  req0_valid  in   1      port 0 request valid
//  req0_ready  out  1      port 0 request accepted this cycle
//  req0_a      in   XLEN   port 0 operand a
//  req0_b      in   XLEN   port 0 operand b
//  req0_shamt  in   5      port 0 shift amount
//  req0_ctrl   in   4      port 0 aluctrl code (`ALU_CTRL_*)
//  req1_*      -    -      identical set for port 1
//  rsp_valid   out  1      result register holds a valid result
//  rsp_ready   in   1      consumer takes the result this cycle
//  rsp_id      out  1      requester that issued the held result
//  rsp_data    out  XLEN   registered aluout
//  rsp_flags   out  4      registered {overflow, zero, lt, ge}
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, rr_last=1 (port 0 wins first). Output regs clear immediately on rstn low.
//  Handshake: a request transfers when reqN_valid && reqN_ready. A response transfers when rsp_valid && rsp_ready.
//  Requesters must hold their inputs stable while valid && !ready. Valid is never dropped before acceptance.
//  can_issue = ~rsp_valid | rsp_ready. Back-to-back issue is allowed in the same cycle the held result drains.
//  Grant (combinational): only one of req0_ready/req1_ready is high, and only when can_issue is high.
//   one valid -> grant it. Both valid -> grant port != rr_last. None -> no grant, ALU inputs driven to 0 with ctrl `ALU_CTRL_ZERO.
//  rr_last updates to the granted id on every accepted request. No update without a grant.
//  Latency: request accepted at edge N -> rsp_valid=1 with data/flags/id after edge N (visible in cycle N+1).
//  State: IDLE (rsp_valid=0) / FULL (rsp_valid=1).
//   IDLE + grant -> FULL. FULL + rsp_ready + grant -> FULL with new result. FULL + rsp_ready + no grant -> IDLE.
//   FULL + !rsp_ready -> FULL with data held and both readys at 0.
//  rsp_data/flags/id are stable while rsp_valid && !rsp_ready.
//  Arithmetic: pure pass-through of alu. Unsupported ctrl codes give data 0 and zero=1. The arbiter never alters width or value.
//  Reset mid-operation: any held result is discarded and any in-flight request is not accepted. Requesters re-present after rstn rises.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins when both are valid. rr_last is kept but ignored.
//  ALU_ARB_FIXED_PRIO_EN undefined: round-robin as above. Either requester waits at most one grant while the other is valid.
// STRUCTURE
//  `XLEN, `ALU_CTRL_* and the new `ALU_ARB_ID_W (1) live in xgriscv_defines.v. No local copies.
//  Sub-module alu_arb_pick: 2-way grant picker (valid0, valid1, rr_last, en -> gnt0, gnt1), holding the macro-selected policy.
//  Instantiates alu once. The operand mux and result register live in alu_arbiter.
// TESTING
//  1 Reset: hold rstn=0 with both valids high -> both readys 0, rsp_valid 0, rsp_data 0. First grant after release goes to port 0.
//  2 Single port: req0 ADD a=32'h7FFF_FFFF b=1, rsp_ready=1 -> next cycle rsp_data=32'h8000_0000, id=0, overflow=1, lt=1.
//  3 Contention: both valid for 4 cycles, rsp_ready=1 -> ids 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN -> ids 0,0,0,0.
//  4 Backpressure: rsp_ready=0 for 3 cycles after a grant -> readys 0, data/id stable. Raising rsp_ready drains and issues in the same cycle.
//  5 LUI/ctrl passthrough: req1 LUI a=0 b=32'h1234_5000 -> rsp_data=32'h1234_5000, id=1. Undefined ctrl 4'b1111 -> data 0, zero=1.
//  6 Mid-op reset: assert rstn low while FULL -> rsp_valid drops asynchronously. No stale result appears after release.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared types for the ALU arbiter slice.
// Policy is chosen by ALU_ARB_FIXED_PRIO_EN inside alu_arb_pick.
`include "xgriscv_defines.sv"

package alu_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_FULL = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [`XLEN-1:0] a;
        logic [`XLEN-1:0] b;
        logic [4:0]       shamt;
        logic [3:0]       ctrl;
    } alu_op_t;

    function automatic alu_op_t alu_op_idle();
        alu_op_t op;
        op      = '0;
        op.ctrl = `ALU_CTRL_ZERO;
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: single-cycle core ALU, flags {overflow, zero, lt, ge} from the result.
`include "xgriscv_defines.sv"

module alu (
    input  logic [`XLEN-1:0] a,
    input  logic [`XLEN-1:0] b,
    input  logic [4:0]       shamt,
    input  logic [3:0]       aluctrl,
    output logic [`XLEN-1:0] aluout,
    output logic             overflow,
    output logic             zero,
    output logic             lt,
    output logic             ge
);

    logic [`XLEN-1:0] sum;
    logic [`XLEN-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        aluout   = '0;
        overflow = 1'b0;
        case (aluctrl)
            `ALU_CTRL_ADD: begin
                aluout   = sum;
                overflow = (a[`XLEN-1] == b[`XLEN-1]) &&
                           (sum[`XLEN-1] != a[`XLEN-1]);
            end
            `ALU_CTRL_SUB: begin
                aluout   = diff;
                overflow = (a[`XLEN-1] != b[`XLEN-1]) &&
                           (diff[`XLEN-1] != a[`XLEN-1]);
            end
            `ALU_CTRL_AND:  aluout = a & b;
            `ALU_CTRL_OR:   aluout = a | b;
            `ALU_CTRL_XOR:  aluout = a ^ b;
            `ALU_CTRL_SLL:  aluout = a << shamt;
            `ALU_CTRL_SRL:  aluout = a >> shamt;
            `ALU_CTRL_SRA:  aluout = $signed(a) >>> shamt;
            `ALU_CTRL_SLT:
                aluout = {{(`XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            `ALU_CTRL_SLTU:
                aluout = {{(`XLEN-1){1'b0}}, a < b};
            `ALU_CTRL_LUI:  aluout = b;
            default:        aluout = '0;
        endcase
    end

    // lt/ge follow the result sign, as the branch unit expects
    assign zero = (aluout == '0);
    assign lt   = aluout[`XLEN-1];
    assign ge   = ~aluout[`XLEN-1];

endmodule

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: 2-way grant picker for the shared ALU.
// ALU_ARB_FIXED_PRIO_EN: port 0 always wins ties; otherwise round-robin.
module alu_arb_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_last,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
    assign gnt0 = en & valid0;
    assign gnt1 = en & valid1 & ~valid0;
`else
    // On a tie, the port that did not win last goes next
    assign gnt0 = en & valid0 & (~valid1 | rr_last);
    assign gnt1 = en & valid1 & (~valid0 | ~rr_last);
`endif

endmodule

// File: rtl/xgriscv_defines.sv
// xgriscv core-wide macros: datapath width, aluctrl codes, arbiter id width.
// Shared by every ALU-related block; included with a guard.
`ifndef XGRISCV_DEFINES_SV
`define XGRISCV_DEFINES_SV

`define XLEN 32

`define ALU_CTRL_ZERO 4'b0000
`define ALU_CTRL_ADD  4'b0001
`define ALU_CTRL_SUB  4'b0010
`define ALU_CTRL_AND  4'b0011
`define ALU_CTRL_OR   4'b0100
`define ALU_CTRL_XOR  4'b0101
`define ALU_CTRL_SLL  4'b0110
`define ALU_CTRL_SRL  4'b0111
`define ALU_CTRL_SRA  4'b1000
`define ALU_CTRL_SLT  4'b1001
`define ALU_CTRL_SLTU 4'b1010
`define ALU_CTRL_LUI  4'b1011

`define ALU_ARB_ID_W 1

`endif

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares the core ALU between EX (port 0) and AGU/CSR (port 1).
// ALU_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
`include "xgriscv_defines.sv"

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN_P = `XLEN
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [XLEN_P-1:0]        req0_a,
    input  logic [XLEN_P-1:0]        req0_b,
    input  logic [4:0]               req0_shamt,
    input  logic [3:0]               req0_ctrl,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [XLEN_P-1:0]        req1_a,
    input  logic [XLEN_P-1:0]        req1_b,
    input  logic [4:0]               req1_shamt,
    input  logic [3:0]               req1_ctrl,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [`ALU_ARB_ID_W-1:0] rsp_id,
    output logic [XLEN_P-1:0]        rsp_data,
    output logic [3:0]               rsp_flags
);

    arb_state_e               state;
    logic [`ALU_ARB_ID_W-1:0] rr_last;
    logic                     can_issue;
    logic                     gnt0;
    logic                     gnt1;
    logic                     gnt;
    alu_op_t                  op;
    logic [XLEN_P-1:0]        aluout;
    logic                     ovf;
    logic                     zero;
    logic                     lt;
    logic                     ge;

    assign rsp_valid = (state == ARB_FULL);
    assign can_issue = ~rsp_valid | rsp_ready;

    // No grant while reset is held, so nothing sneaks in on release
    alu_arb_pick u_pick (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .rr_last (rr_last[0]),
        .en      (can_issue & rstn),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign gnt        = gnt0 | gnt1;

    always_comb begin
        op = alu_op_idle();
        unique case (1'b1)
            gnt0: op = '{a: req0_a, b: req0_b,
                         shamt: req0_shamt, ctrl: req0_ctrl};
            gnt1: op = '{a: req1_a, b: req1_b,
                         shamt: req1_shamt, ctrl: req1_ctrl};
            default: ;
        endcase
    end

    alu u_alu (
        .a        (op.a),
        .b        (op.b),
        .shamt    (op.shamt),
        .aluctrl  (op.ctrl),
        .aluout   (aluout),
        .overflow (ovf),
        .zero     (zero),
        .lt       (lt),
        .ge       (ge)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ARB_IDLE;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rr_last   <= `ALU_ARB_ID_W'(1);
        end else begin
            unique case (state)
                ARB_IDLE: if (gnt) state <= ARB_FULL;
                ARB_FULL: if (rsp_ready && !gnt) state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
            if (gnt) begin
                rsp_id    <= `ALU_ARB_ID_W'(gnt1);
                rsp_data  <= aluout;
                rsp_flags <= {ovf, zero, lt, ge};
                rr_last   <= `ALU_ARB_ID_W'(gnt1);
            end
        end
    end

endmodule
